// File: rtl/mem_pkg.sv
// Shared types and constants for the multicycle core's memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } t_mem_state;

  localparam logic [3:0] BE_WORD          = 4'b1111;
  localparam int         WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (be_i == BE_WORD) begin
        mem_q[waddr_i] <= wdata_i;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder_mc.sv
// Memory-side responder: latches one request, waits LATENCY cycles, answers for one cycle.
module mem_responder_mc
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        be_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [1:0]        state_o
);

  localparam int               IDX_W     = $clog2(DEPTH_WORDS);
  localparam int               WIDX_W    = ADDR_W - WORD_OFFSET_BITS;
  localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);
  localparam logic [3:0]       LAT4      = 4'(LATENCY);

  t_mem_state        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d;
  logic [3:0]        be_q;

  logic              err_in, latch_en, load;
  logic              rd_we, rd_err, mem_we;
  logic [IDX_W-1:0]  idx_in, rd_idx;
  logic [31:0]       mem_rdata;

  assign err_in = (addr_i[WORD_OFFSET_BITS-1:0] != '0) |
                  (addr_i[ADDR_W-1:WORD_OFFSET_BITS] >= DEPTH_LIM);
  assign idx_in = addr_i[IDX_W+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];

  // With zero latency the read happens on the accept edge, so use the live inputs in IDLE.
  assign rd_idx = (state_q == IDLE) ? idx_in : idx_q;
  assign rd_we  = (state_q == IDLE) ? we_i   : we_q;
  assign rd_err = (state_q == IDLE) ? err_in : err_q;
  assign mem_we = (state_q == RESP) & we_q & ~err_q & ~rst_i;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (IDX_W)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .be_i   (be_q),
    .waddr_i(idx_q),
    .wdata_i(wdata_q),
    .raddr_i(rd_idx),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          latch_en = 1'b1;
          cnt_d    = LAT4;
          load     = (LATENCY == 0);
          state_d  = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          load    = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdata_d = (rd_we | rd_err) ? '0 : mem_rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        we_q    <= we_i;
        err_q   <= err_in;
        idx_q   <= idx_in;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      if (load) rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = (state_q == RESP);
  assign err_o   = (state_q == RESP) & err_q;
  assign busy_o  = (state_q == WAIT) | (state_q == RESP);
  assign state_o = state_q;

endmodule
